mdr_result_demux: RTL and testbench

Result distributor at the output end of the MDR datapath: accepts one result word per handshake from the shared arithmetic core and steers it, by a 2-bit destination code, into one of three single-entry output channels (A, B, C). Each channel holds its word until its downstream consumer takes it with a valid/ready handshake. It is the inverse of the operand selection at the datapath input and gives the core backpressure when the addressed channel is full.

---
 rtl/mdr_result_demux.sv | 112 +++++++++++
 tb/tb_mdr_result_demux.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mdr_result_demux.sv
// mdr_result_demux: steers each accepted result word from the shared arithmetic
// core into one of three single-entry output channels (A, B, C). Each channel
// holds its word until the downstream consumer takes it; the core sees
// backpressure only when the addressed channel is full and not draining.
module mdr_result_demux #(
   parameter int DW     = 4,
   parameter int DW_SEL = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DW-1:0]     i_data,
   input  logic [DW_SEL-1:0] i_sel,
   input  logic              i_valid,
   output logic              o_ready,
   output logic [DW-1:0]     o_a_data,
   output logic [DW-1:0]     o_b_data,
   output logic [DW-1:0]     o_c_data,
   output logic              o_a_valid,
   output logic              o_b_valid,
   output logic              o_c_valid,
   input  logic              i_a_ready,
   input  logic              i_b_ready,
   input  logic              i_c_ready,
   output logic [1:0]        o_pend
);

   logic [DW-1:0] data_a_q, data_a_d;
   logic [DW-1:0] data_b_q, data_b_d;
   logic [DW-1:0] data_c_q, data_c_d;
   logic          valid_a_q, valid_a_d;
   logic          valid_b_q, valid_b_d;
   logic          valid_c_q, valid_c_d;
   logic [1:0]    pend_q, pend_d;

   logic          tgt_a, tgt_b, tgt_c;
   logic          accept;

   // Decode the target channel (code 2'b11 aliases to C) and form o_ready,
   // which depends only on i_sel, channel state and the ready inputs.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      tgt_a = 1'b0;
      tgt_b = 1'b0;
      tgt_c = 1'b0;
      unique case (i_sel[1:0])
         2'b00:   tgt_a = 1'b1;
         2'b01:   tgt_b = 1'b1;
         default: tgt_c = 1'b1;
      endcase
      o_ready = (tgt_a & (~valid_a_q | i_a_ready))
              | (tgt_b & (~valid_b_q | i_b_ready))
              | (tgt_c & (~valid_c_q | i_c_ready));
      accept  = i_valid & o_ready;
   end

   // Next state per channel: a fill wins over a drain (old word leaves, new
   // word lands, valid stays set); a drain alone clears valid but keeps data.
   always_comb begin
      data_a_d  = data_a_q;
      data_b_d  = data_b_q;
      data_c_d  = data_c_q;
      valid_a_d = valid_a_q & ~i_a_ready;
      valid_b_d = valid_b_q & ~i_b_ready;
      valid_c_d = valid_c_q & ~i_c_ready;
      if (accept && tgt_a) begin
         data_a_d  = i_data;
         valid_a_d = 1'b1;
      end
      if (accept && tgt_b) begin
         data_b_d  = i_data;
         valid_b_d = 1'b1;
      end
      if (accept && tgt_c) begin
         data_c_d  = i_data;
         valid_c_d = 1'b1;
      end
      pend_d = {1'b0, valid_a_d} + {1'b0, valid_b_d} + {1'b0, valid_c_d};
   end

   // Channel and occupancy registers; reset clears held words and data.
   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge
      // values regardless of statement order.
      if (!i_rst_n) begin
         data_a_q  <= '0;
         data_b_q  <= '0;
         data_c_q  <= '0;
         valid_a_q <= 1'b0;
         valid_b_q <= 1'b0;
         valid_c_q <= 1'b0;
         pend_q    <= 2'd0;
      end else begin
         data_a_q  <= data_a_d;
         data_b_q  <= data_b_d;
         data_c_q  <= data_c_d;
         valid_a_q <= valid_a_d;
         valid_b_q <= valid_b_d;
         valid_c_q <= valid_c_d;
         pend_q    <= pend_d;
      end
   end

   assign o_a_data  = data_a_q;
   assign o_b_data  = data_b_q;
   assign o_c_data  = data_c_q;
   assign o_a_valid = valid_a_q;
   assign o_b_valid = valid_b_q;
   assign o_c_valid = valid_c_q;
   assign o_pend    = pend_q;

endmodule

// File: tb/tb_mdr_result_demux.sv
// Bench for mdr_result_demux: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a channel-level
// reference model.
`timescale 1ns/1ps
module tb_mdr_result_demux;

   localparam int DW = 4;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic [DW-1:0] i_data;
   logic [1:0]    i_sel;
   logic          i_valid;
   logic          o_ready;
   logic [DW-1:0] o_a_data, o_b_data, o_c_data;
   logic          o_a_valid, o_b_valid, o_c_valid;
   logic          i_a_ready, i_b_ready, i_c_ready;
   logic [1:0]    o_pend;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Reference model: one slot per channel (0=A, 1=B, 2=C).
   bit            m_full [3];
   logic [DW-1:0] m_word [3];

   mdr_result_demux #(.DW(DW), .DW_SEL(2)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_data    (i_data),
      .i_sel     (i_sel),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .o_a_data  (o_a_data),
      .o_b_data  (o_b_data),
      .o_c_data  (o_c_data),
      .o_a_valid (o_a_valid),
      .o_b_valid (o_b_valid),
      .o_c_valid (o_c_valid),
      .i_a_ready (i_a_ready),
      .i_b_ready (i_b_ready),
      .i_c_ready (i_c_ready),
      .o_pend    (o_pend)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int chan_of(input logic [1:0] s);
      return (s == 2'b11) ? 2 : int'(s);
   endfunction

   function automatic bit rdy_of(input int ch);
      return (ch == 0) ? i_a_ready : (ch == 1) ? i_b_ready : i_c_ready;
   endfunction

   // Model update: accept into an empty-or-draining slot, drain on ready.
   always @(posedge i_clk) begin
      int  t;
      bit  acc;
      t   = chan_of(i_sel);
      acc = i_valid && (!m_full[t] || rdy_of(t));
      for (int ch = 0; ch < 3; ch++) begin
         if (!i_rst_n) begin
            m_full[ch] <= 1'b0;
            m_word[ch] <= '0;
         end else if (acc && ch == t) begin
            m_full[ch] <= 1'b1;
            m_word[ch] <= i_data;
         end else if (rdy_of(ch)) begin
            m_full[ch] <= 1'b0;
         end
      end
   end

   // Compare process: every cycle, mid-period, all outputs against the model.
   always @(negedge i_clk) begin
      int exp_pend;
      int t;
      if (chk_en) begin
         exp_pend = int'(m_full[0]) + int'(m_full[1]) + int'(m_full[2]);
         t        = chan_of(i_sel);
         check("m_a_valid", 32'(o_a_valid), 32'(m_full[0]));
         check("m_b_valid", 32'(o_b_valid), 32'(m_full[1]));
         check("m_c_valid", 32'(o_c_valid), 32'(m_full[2]));
         check("m_a_data",  32'(o_a_data),  32'(m_word[0]));
         check("m_b_data",  32'(o_b_data),  32'(m_word[1]));
         check("m_c_data",  32'(o_c_data),  32'(m_word[2]));
         check("m_pend",    32'(o_pend),    32'(exp_pend));
         check("m_ready",   32'(o_ready),   32'(!m_full[t] || rdy_of(t)));
      end
   end

   task automatic drive(input bit rst_n, input bit v, input logic [1:0] s,
                        input logic [DW-1:0] d, input bit ar, input bit br, input bit cr);
      i_rst_n   = rst_n;
      i_valid   = v;
      i_sel     = s;
      i_data    = d;
      i_a_ready = ar;
      i_b_ready = br;
      i_c_ready = cr;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      drive(1'b0, 1'b1, 2'b00, 4'hF, 1'b0, 1'b0, 1'b0);
      tick();
      chk_en = 1'b1;
      tick();

      // Reset/idle
      drive(1'b1, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
      check("rst_valids", 32'({o_a_valid, o_b_valid, o_c_valid}), 32'h0);
      check("rst_data", 32'({o_a_data, o_b_data, o_c_data}), 32'h0);
      check("rst_pend", 32'(o_pend), 32'h0);
      for (int s = 0; s < 4; s++) begin
         i_sel = 2'(s);
         #0.5;
         check("rst_ready", 32'(o_ready), 32'h1);
      end

      // Steering
      drive(1'b1, 1'b1, 2'b00, 4'h3, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b1, 2'b01, 4'h5, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b1, 2'b10, 4'h9, 1'b0, 1'b0, 1'b0); tick();
      check("steer_a", 32'(o_a_data), 32'h3);
      check("steer_b", 32'(o_b_data), 32'h5);
      check("steer_c", 32'(o_c_data), 32'h9);
      check("steer_valids", 32'({o_a_valid, o_b_valid, o_c_valid}), 32'h7);
      check("steer_pend", 32'(o_pend), 32'h3);

      // Alias and backpressure
      drive(1'b1, 1'b1, 2'b11, 4'hA, 1'b0, 1'b0, 1'b0);
      #1;
      check("alias_bp_ready", 32'(o_ready), 32'h0);
      tick();
      check("alias_c_held", 32'(o_c_data), 32'h9);
      i_c_ready = 1'b1;
      #1;
      check("alias_ready", 32'(o_ready), 32'h1);
      check("alias_deliver", 32'(o_c_data), 32'h9);
      tick();
      check("alias_c_new", 32'(o_c_data), 32'hA);
      check("alias_c_valid", 32'(o_c_valid), 32'h1);
      check("alias_pend", 32'(o_pend), 32'h3);

      // Drain everything
      drive(1'b1, 1'b0, 2'b00, 4'h0, 1'b1, 1'b1, 1'b1); tick();
      check("drain_pend", 32'(o_pend), 32'h0);

      // Streaming to B
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, 1'b1, 2'b01, 4'(k), 1'b0, 1'b1, 1'b0);
         #1;
         check("stream_ready", 32'(o_ready), 32'h1);
         tick();
         check("stream_b_data", 32'(o_b_data), 32'(k));
         check("stream_b_valid", 32'(o_b_valid), 32'h1);
      end
      drive(1'b1, 1'b0, 2'b01, 4'h0, 1'b0, 1'b1, 1'b0); tick();

      // Independent drain
      drive(1'b1, 1'b1, 2'b00, 4'h2, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b1, 2'b01, 4'h7, 1'b1, 1'b0, 1'b0); tick();
      check("indep_a_valid", 32'(o_a_valid), 32'h0);
      check("indep_b_data", 32'(o_b_data), 32'h7);
      check("indep_b_valid", 32'(o_b_valid), 32'h1);
      check("indep_pend", 32'(o_pend), 32'h1);

      // Reset mid-operation
      drive(1'b1, 1'b1, 2'b00, 4'h4, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b1, 2'b10, 4'h6, 1'b0, 1'b0, 1'b0); tick();
      check("full_pend", 32'(o_pend), 32'h3);
      drive(1'b0, 1'b1, 2'b01, 4'hE, 1'b1, 1'b1, 1'b1); tick();
      drive(1'b1, 1'b0, 2'b00, 4'h0, 1'b1, 1'b1, 1'b1);
      check("mid_rst_valids", 32'({o_a_valid, o_b_valid, o_c_valid}), 32'h0);
      check("mid_rst_pend", 32'(o_pend), 32'h0);
      tick();
      tick();
      check("post_rst_valids", 32'({o_a_valid, o_b_valid, o_c_valid}), 32'h0);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         drive(($urandom_range(0, 49) != 0), 1'($urandom), 2'($urandom),
               4'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 2) == 0));
         tick();
      end

      drive(1'b1, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
